// File: rtl/alu_issue_arbiter_if.sv
// rtl/alu_issue_arbiter_if.sv - request, ALU and response bundle for the ALU issue arbiter
interface alu_issue_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [3:0]  req0_op;
  logic [1:0]  req0_mode;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic [3:0]  req1_op;
  logic [1:0]  req1_mode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [1:0]  alu_mode;
  logic [31:0] alu_out;
  logic        alu_z;
  logic        alu_eq;
  logic        alu_gt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_z;
  logic        rsp_eq;
  logic        rsp_gt;
  logic        rsp_err;
  logic        busy;

  // Environment side: requesters, the ALU itself and the response consumer.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_mode,
    output req1_valid, req1_a, req1_b, req1_op, req1_mode,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_opcode, alu_mode,
    output alu_out, alu_z, alu_eq, alu_gt,
    input  rsp_valid, rsp_id, rsp_data, rsp_z, rsp_eq, rsp_gt, rsp_err, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_mode,
    input  req1_valid, req1_a, req1_b, req1_op, req1_mode,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_opcode, alu_mode,
    input  alu_out, alu_z, alu_eq, alu_gt,
    output rsp_valid, rsp_id, rsp_data, rsp_z, rsp_eq, rsp_gt, rsp_err, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin sharing of one 16-bit ALU between two requesters
module alu_issue_arbiter #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input logic               clk,
  input logic               rst,
  alu_issue_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_t      state, state_nxt;
  logic        rr_ptr;
  logic [3:0]  cnt;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_code;
  logic [1:0]  op_mode;
  logic        op_id;
  logic        gnt0, gnt1, accept, capture;
  logic [15:0] sel_a, sel_b;
  logic [3:0]  sel_op, sel_cnt;
  logic [1:0]  sel_mode;
  logic        op_is_div;
  logic [31:0] rsp_data_q;
  logic        rsp_id_q, rsp_z_q, rsp_eq_q, rsp_gt_q, rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    capture         = 1'b0;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.alu_a       = 16'h0;
    bus.alu_b       = 16'h0;
    bus.alu_opcode  = 4'h0;
    bus.alu_mode    = 2'b11;
    bus.rsp_valid   = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      IDLE: begin
        // The non-pointed requester wins only when the pointed one is idle.
        gnt0 = bus.req0_valid & (~rr_ptr | ~bus.req1_valid);
        gnt1 = bus.req1_valid & (rr_ptr | ~bus.req0_valid);
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        if (gnt0 | gnt1) state_nxt = EXEC;
      end
      EXEC: begin
        bus.alu_a      = op_a;
        bus.alu_b      = op_b;
        bus.alu_opcode = op_code;
        bus.alu_mode   = op_mode;
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = gnt0 | gnt1;
  assign sel_a    = gnt1 ? bus.req1_a    : bus.req0_a;
  assign sel_b    = gnt1 ? bus.req1_b    : bus.req0_b;
  assign sel_op   = gnt1 ? bus.req1_op   : bus.req0_op;
  assign sel_mode = gnt1 ? bus.req1_mode : bus.req0_mode;

  // Divide by zero skips the long divide latency and errors out after one cycle.
  always_comb begin
    sel_cnt = 4'd0;
    if (sel_mode == 2'b00 && sel_op == 4'b0010)
      sel_cnt = MUL_CNT;
    else if (sel_mode == 2'b00 && sel_op == 4'b0100 && sel_b != 16'h0)
      sel_cnt = DIV_CNT;
  end

  assign op_is_div = (op_mode == 2'b00) && (op_code == 4'b0100);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      cnt        <= 4'd0;
      op_a       <= 16'h0;
      op_b       <= 16'h0;
      op_code    <= 4'h0;
      op_mode    <= 2'b00;
      op_id      <= 1'b0;
      rsp_data_q <= 32'h0;
      rsp_id_q   <= 1'b0;
      rsp_z_q    <= 1'b0;
      rsp_eq_q   <= 1'b0;
      rsp_gt_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_a    <= sel_a;
        op_b    <= sel_b;
        op_code <= sel_op;
        op_mode <= sel_mode;
        op_id   <= gnt1;
        cnt     <= sel_cnt;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_id_q <= op_id;
        if (op_mode == 2'b11) begin
          {rsp_data_q, rsp_z_q, rsp_eq_q, rsp_gt_q, rsp_err_q} <= {32'h0, 3'b000, 1'b1};
        end else if (op_is_div && op_b == 16'h0) begin
          {rsp_data_q, rsp_z_q, rsp_eq_q, rsp_gt_q, rsp_err_q} <= {32'h0000_FFFF, 3'b000, 1'b1};
        end else begin
          {rsp_data_q, rsp_z_q, rsp_eq_q, rsp_gt_q, rsp_err_q} <=
            {bus.alu_out, bus.alu_z, bus.alu_eq, bus.alu_gt, 1'b0};
        end
      end
      if (state == RESP && bus.rsp_ready) rr_ptr <= ~rsp_id_q;
    end
  end

  assign bus.rsp_id   = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_z    = rsp_z_q;
  assign bus.rsp_eq   = rsp_eq_q;
  assign bus.rsp_gt   = rsp_gt_q;
  assign bus.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - scoreboard bench for alu_issue_arbiter
module tb_alu_issue_arbiter;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_arbiter_if bus();

  alu_issue_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        z, eq, gt, err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exec_cycles = 0;
  bit   rsp_seen = 0;
  logic [35:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op, input logic [1:0] mode);
    logic [31:0] r;
    r = 32'h0;
    case (mode)
      2'b00: case (op)
        4'b0001: r = 32'(a) + 32'(b);
        4'b0010: r = 32'(a) * 32'(b);
        4'b0100: r = (b == 16'h0) ? 32'h0 : 32'(a / b);
        default: r = 32'h0;
      endcase
      2'b01: case (op)
        4'b0000: r = 32'(a & b);
        4'b0001: r = 32'(a | b);
        4'b0010: r = 32'(a ^ b);
        default: r = 32'h0;
      endcase
      2'b10: r = 32'(a) << b[3:0];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always_comb begin
    bus.alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_mode);
    bus.alu_z   = (bus.alu_out == 32'h0);
    bus.alu_eq  = (bus.alu_a == bus.alu_b);
    bus.alu_gt  = (bus.alu_a > bus.alu_b);
  end

  function automatic exp_t mk_exp(input logic id, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] op, input logic [1:0] mode, input int acc);
    exp_t e;
    e.id = id; e.acc = acc; e.lat = 1;
    e.data = 32'h0; e.z = 0; e.eq = 0; e.gt = 0; e.err = 0;
    if (mode == 2'b11) begin
      e.err = 1;
    end else if (mode == 2'b00 && op == 4'b0100 && b == 16'h0) begin
      e.data = 32'h0000_FFFF;
      e.err  = 1;
    end else begin
      e.data = alu_fn(a, b, op, mode);
      e.z = (e.data == 32'h0); e.eq = (a == b); e.gt = (a > b);
      if (mode == 2'b00 && op == 4'b0010) e.lat = MUL_LAT;
      if (mode == 2'b00 && op == 4'b0100) e.lat = DIV_LAT;
    end
    return e;
  endfunction

  // Monitor: handshakes are decided by the values seen at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      rsp_seen = 0;
    end else begin
      if (bus.busy && !bus.rsp_valid) exec_cycles++;
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(mk_exp(1'b0, bus.req0_a, bus.req0_b, bus.req0_op, bus.req0_mode, cyc));
        grant_log.push_back(0);
        exec_cycles = 0;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(mk_exp(1'b1, bus.req1_a, bus.req1_b, bus.req1_op, bus.req1_mode, cyc));
        grant_log.push_back(1);
        exec_cycles = 0;
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
        end else begin
          if (!rsp_seen) begin
            check("rsp_id",   32'(bus.rsp_id), 32'(sb[0].id));
            check("rsp_data", bus.rsp_data, sb[0].data);
            check("rsp_flags", 32'({bus.rsp_z, bus.rsp_eq, bus.rsp_gt}),
                  32'({sb[0].z, sb[0].eq, sb[0].gt}));
            check("rsp_err",  32'(bus.rsp_err), 32'(sb[0].err));
            check("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat + 1));
            check("exec_cycles", 32'(exec_cycles), 32'(sb[0].lat));
            snap = {bus.rsp_data, bus.rsp_id, bus.rsp_z, bus.rsp_eq, bus.rsp_gt};
            rsp_seen = 1;
          end else begin
            check("rsp_stable", 32'({bus.rsp_data, bus.rsp_id, bus.rsp_z, bus.rsp_eq, bus.rsp_gt} != snap), 32'h0);
          end
          check("ready_in_resp", 32'({bus.req0_ready, bus.req1_ready}), 32'h0);
          check("busy_in_resp", 32'(bus.busy), 32'h1);
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            rsp_seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [1:0] mode);
    int n;
    logic rdy;
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_mode = mode; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_mode = mode; bus.req0_valid = 1'b1;
    end
    n = 0;
    forever begin
      @(negedge clk);
      rdy = id ? bus.req1_ready : bus.req0_ready;
      if (rdy) break;
      n++;
      if (n > 60) begin
        check("issue_timeout", 32'(rdy), 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1;
    // Scramble operands after the handshake; the in-flight op must not notice.
    if (id) begin
      bus.req1_valid = 1'b0; bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom);
    end else begin
      bus.req0_valid = 1'b0; bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || bus.busy) && n < 100);
    check("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'h0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_alu_mode"},  32'(bus.alu_mode), 32'h3);
    check({tag, "_alu_ops"},   32'({bus.alu_a, bus.alu_b} | 32'(bus.alu_opcode)), 32'h0);
    check({tag, "_rsp_regs"},  bus.rsp_data | 32'({bus.rsp_id, bus.rsp_z, bus.rsp_eq, bus.rsp_gt, bus.rsp_err}), 32'h0);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0; bus.req0_mode = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0; bus.req1_mode = 0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention twice: pointer starts at 0, rotates to 1, then returns to 0.
    fork
      issue(1'b0, 16'd10, 16'd20, 4'b0001, 2'b00);
      issue(1'b1, 16'h0F0F, 16'h00FF, 4'b0000, 2'b01);
    join
    wait_idle();
    @(posedge clk); #1;
    fork
      issue(1'b0, 16'd7, 16'd7, 4'b0001, 2'b00);
      issue(1'b1, 16'hAAAA, 16'h5555, 4'b0010, 2'b01);
    join
    wait_idle();
    check("grant_order", 32'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), 32'b0101);

    @(posedge clk); #1;
    issue(1'b0, 16'h0003, 16'h0005, 4'b0001, 2'b00);
    wait_idle();
    check("add_result", bus.rsp_data, 32'h8);
    @(posedge clk); #1;
    issue(1'b1, 16'd100, 16'd7, 4'b0100, 2'b00);
    issue(1'b0, 16'd300, 16'd400, 4'b0010, 2'b00);
    issue(1'b1, 16'd55, 16'd0, 4'b0100, 2'b00);
    issue(1'b0, 16'h1234, 16'h0001, 4'b0001, 2'b11);
    issue(1'b1, 16'h0001, 16'd3, 4'b0000, 2'b10);
    issue(1'b0, 16'h0000, 16'h0000, 4'b0001, 2'b00);
    wait_idle();

    // Back-pressure with a second requester waiting.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 16'd9, 16'd4, 4'b0001, 2'b00);
    bus.req1_a = 16'd6; bus.req1_b = 16'd2; bus.req1_op = 4'b0100; bus.req1_mode = 2'b00;
    bus.req1_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 20);
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_busy", 32'(bus.busy), 32'h0);
    issue(1'b1, 16'd6, 16'd2, 4'b0100, 2'b00);
    wait_idle();

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    issue(1'b0, 16'd100, 16'd7, 4'b0100, 2'b00);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_idle", 32'(bus.busy), 32'h0);
    base = grant_log.size();
    @(posedge clk); #1;
    fork
      issue(1'b1, 16'd40, 16'd2, 4'b0001, 2'b00);
      issue(1'b0, 16'd50, 16'd3, 4'b0001, 2'b00);
    join
    wait_idle();
    check("post_rst_grant", 32'(grant_log[base]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
